// File: rtl/riscv_dot_acc_seq.sv
// Dot-product sequencer: streams packed operand pairs into the subword multiplier,
// accumulates through dot_op_c, then rounds/ReLUs/saturates and presents one result.
module riscv_dot_acc_seq #(
  parameter int         LEN_W    = 8,
  parameter logic [2:0] OP_DOT8  = 3'b110,
  parameter logic [2:0] OP_DOT16 = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             mode_i,
  input  logic [1:0]       signed_i,
  input  logic [31:0]      bias_i,
  input  logic [4:0]       shift_i,
  input  logic             relu_i,
  input  logic             sat8_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  output logic             mult_enable_o,
  output logic [2:0]       mult_operator_o,
  output logic [1:0]       mult_dot_signed_o,
  output logic [31:0]      mult_dot_op_a_o,
  output logic [31:0]      mult_dot_op_b_o,
  output logic [31:0]      mult_dot_op_c_o,
  input  logic [31:0]      mult_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_data_o,
  output logic             busy_o
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, POST, DONE} state_e;

  state_e           state_q;
  logic [31:0]      acc_q;
  logic [31:0]      outData_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             mode_q;
  logic [1:0]       signed_q;
  logic [4:0]       shiftAmt_q;
  logic             relu_q;
  logic             sat8_q;
  logic             inReady_q;
  logic             outValid_q;

  logic [LEN_W-1:0]   cntInc;
  logic signed [32:0] accExt;
  logic signed [32:0] roundBias;
  logic signed [32:0] postVal;
  logic [31:0]        outData_d;

  assign cntInc = cnt_q + LEN_W'(1);

  // Post-processing is done one bit wider so the rounding add cannot overflow.
  always_comb begin
    accExt    = {acc_q[31], acc_q};
    roundBias = '0;
    if (shiftAmt_q != 5'd0) begin
      roundBias = 33'sd1 <<< (shiftAmt_q - 5'd1);
    end
    postVal = (accExt + roundBias) >>> shiftAmt_q;
    if (relu_q && (postVal < 33'sd0)) begin
      postVal = '0;
    end
    if (sat8_q) begin
      if (postVal > 33'sd127) begin
        postVal = 33'sd127;
      end else if (postVal < -33'sd128) begin
        postVal = -33'sd128;
      end
    end
    outData_d = postVal[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      outData_q  <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      signed_q   <= '0;
      shiftAmt_q <= '0;
      relu_q     <= 1'b0;
      sat8_q     <= 1'b0;
      inReady_q  <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q      <= len_i;
            mode_q     <= mode_i;
            signed_q   <= signed_i;
            shiftAmt_q <= shift_i;
            relu_q     <= relu_i;
            sat8_q     <= sat8_i;
            acc_q      <= bias_i;
            cnt_q      <= '0;
            if (len_i == '0) begin
              state_q <= POST;
            end else begin
              state_q   <= FETCH;
              inReady_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (in_valid_i) begin
            state_q   <= WAIT;
            inReady_q <= 1'b0;
          end
        end
        // The multiplier result for the pair issued last cycle is valid now.
        WAIT: begin
          acc_q <= mult_result_i;
          cnt_q <= cntInc;
          if (cntInc == len_q) begin
            state_q <= POST;
          end else begin
            state_q   <= FETCH;
            inReady_q <= 1'b1;
          end
        end
        POST: begin
          outData_q  <= outData_d;
          outValid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            outValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o        = inReady_q;
  assign mult_enable_o     = inReady_q & in_valid_i;
  assign mult_operator_o   = mode_q ? OP_DOT16 : OP_DOT8;
  assign mult_dot_signed_o = signed_q;
  assign mult_dot_op_a_o   = in_a_i;
  assign mult_dot_op_b_o   = in_b_i;
  assign mult_dot_op_c_o   = acc_q;
  assign out_valid_o       = outValid_q;
  assign out_data_o        = outData_q;
  assign busy_o            = (state_q != IDLE);

endmodule
